// File: rtl/layer_mac_scheduler_if.sv
`default_nettype none
// ============================================================================
// Module   : layer_mac_scheduler_if
// Brief    : Input-vector, weight-ROM and output-vector signals of the layer MAC scheduler.
// Revision : 1.0
// ============================================================================
interface layer_mac_scheduler_if #(
    parameter int N_IN  = 15,
    parameter int N_OUT = 8,
    parameter int DW    = 16,
    parameter int AW    = 8
);
    logic                  in_valid;
    logic                  in_ready;
    logic [N_IN*DW-1:0]    in_vec;
    logic                  w_en;
    logic [AW-1:0]         w_addr;
    logic [DW-1:0]         w_data;
    logic                  out_valid;
    logic                  out_ready;
    logic [N_OUT*DW-1:0]   out_vec;
    logic                  busy;

    // Environment side: upstream layer, weight ROM and downstream layer.
    modport master (
        output in_valid, in_vec, w_data, out_ready,
        input  in_ready, w_en, w_addr, out_valid, out_vec, busy
    );

    // Scheduler side.
    modport slave (
        input  in_valid, in_vec, w_data, out_ready,
        output in_ready, w_en, w_addr, out_valid, out_vec, busy
    );
endinterface
`default_nettype wire

// File: rtl/layer_mac_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : layer_mac_scheduler
// Brief    : One shared 16-bit MAC time-multiplexed over every neuron of a dense ReLU layer.
// Revision : 1.0
// ============================================================================
module layer_mac_scheduler #(
    parameter int N_IN  = 15,
    parameter int N_OUT = 8,
    parameter int DW    = 16,
    parameter int AW    = 8
) (
    input  wire logic             clk,
    input  wire logic             reset,
    layer_mac_scheduler_if.slave  bus
);
    localparam int c_cw = $clog2(N_IN + 1);
    localparam int c_nw = (N_OUT > 1) ? $clog2(N_OUT) : 1;
    localparam logic [c_cw-1:0] c_bias_slot = c_cw'(N_IN);
    localparam logic [c_nw-1:0] c_last_n    = c_nw'(N_OUT - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_WRITE = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t               r_state;
    logic [c_cw-1:0]      r_c;
    logic [c_nw-1:0]      r_n;
    logic [DW-1:0]        r_acc;
    logic [N_IN*DW-1:0]   r_xv;
    logic [N_IN*DW-1:0]   r_xs;
    logic                 r_in_ready;
    logic                 r_w_en;
    logic [AW-1:0]        r_w_addr;
    logic                 r_out_valid;
    logic [N_OUT*DW-1:0]  r_out_vec;
    logic                 r_busy;

    logic [DW-1:0]        w_prod;
    logic [DW-1:0]        w_sum;
    logic [DW-1:0]        w_relu;

    // r_xs is a working copy shifted one element per accumulate, so its low
    // element always pairs with the weight arriving on w_data.
    assign w_prod = r_xs[DW-1:0] * bus.w_data;
    assign w_sum  = r_acc + bus.w_data;
    assign w_relu = w_sum[DW-1] ? '0 : w_sum;

    assign bus.in_ready  = r_in_ready;
    assign bus.w_en      = r_w_en;
    assign bus.w_addr    = r_w_addr;
    assign bus.out_valid = r_out_valid;
    assign bus.out_vec   = r_out_vec;
    assign bus.busy      = r_busy;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_c         <= '0;
            r_n         <= '0;
            r_acc       <= '0;
            r_xv        <= '0;
            r_xs        <= '0;
            r_in_ready  <= 1'b1;
            r_w_en      <= 1'b0;
            r_w_addr    <= '0;
            r_out_valid <= 1'b0;
            r_out_vec   <= '0;
            r_busy      <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.in_valid && r_in_ready) begin
                        r_xv       <= bus.in_vec;
                        r_xs       <= bus.in_vec;
                        r_n        <= '0;
                        r_c        <= '0;
                        r_acc      <= '0;
                        r_in_ready <= 1'b0;
                        r_w_en     <= 1'b1;
                        r_w_addr   <= '0;
                        r_busy     <= 1'b1;
                        r_state    <= S_RUN;
                    end
                end

                S_RUN: begin
                    // Data for address c-1 is on w_data now; slot 0 has nothing yet.
                    if (r_c != '0) begin
                        r_acc <= r_acc + w_prod;
                        r_xs  <= r_xs >> DW;
                    end
                    if (r_c == c_bias_slot) begin
                        r_w_en  <= 1'b0;
                        r_c     <= '0;
                        r_state <= S_WRITE;
                    end else begin
                        r_c      <= r_c + 1'b1;
                        r_w_addr <= r_w_addr + 1'b1;
                    end
                end

                S_WRITE: begin
                    r_out_vec[r_n*DW +: DW] <= w_relu;
                    r_acc <= '0;
                    r_c   <= '0;
                    r_xs  <= r_xv;
                    if (r_n == c_last_n) begin
                        r_busy      <= 1'b0;
                        r_out_valid <= 1'b1;
                        r_state     <= S_DONE;
                    end else begin
                        // Bias address of neuron n plus one is the first weight of n+1.
                        r_n      <= r_n + 1'b1;
                        r_w_en   <= 1'b1;
                        r_w_addr <= r_w_addr + 1'b1;
                        r_state  <= S_RUN;
                    end
                end

                S_DONE: begin
                    if (r_out_valid && bus.out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= S_IDLE;
                    end
                end

                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_layer_mac_scheduler.sv
`default_nettype none
// Bench for layer_mac_scheduler: behavioural weight ROM, reference model feeding a
// result scoreboard, plus address-trace, latency, stall and reset-abort checks.
module tb_layer_mac_scheduler;
    localparam int N_IN  = 15;
    localparam int N_OUT = 8;
    localparam int DW    = 16;
    localparam int AW    = 8;
    localparam int LAT   = N_OUT * (N_IN + 2);

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    logic [DW-1:0]        rom [0:(1<<AW)-1];
    logic [127:0]         sb_q [$];

    layer_mac_scheduler_if #(.N_IN(N_IN), .N_OUT(N_OUT), .DW(DW), .AW(AW)) bus ();

    layer_mac_scheduler #(.N_IN(N_IN), .N_OUT(N_OUT), .DW(DW), .AW(AW)) u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (bus.w_en) bus.w_data <= rom[bus.w_addr];
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [127:0] model(input logic [N_IN*DW-1:0] x);
        logic [127:0] res;
        logic [DW-1:0] s;
        res = '0;
        for (int n = 0; n < N_OUT; n++) begin
            s = rom[n*(N_IN+1) + N_IN];
            for (int k = 0; k < N_IN; k++)
                s = s + DW'(x[k*DW +: DW] * rom[n*(N_IN+1) + k]);
            res[n*DW +: DW] = s[DW-1] ? '0 : s;
        end
        return res;
    endfunction

    task automatic clear_rom();
        for (int i = 0; i < (1<<AW); i++) rom[i] = '0;
    endtask

    task automatic rand_rom();
        for (int i = 0; i < (1<<AW); i++) rom[i] = DW'($urandom);
    endtask

    function automatic logic [N_IN*DW-1:0] rand_vec();
        logic [N_IN*DW-1:0] v;
        for (int k = 0; k < N_IN; k++) v[k*DW +: DW] = DW'($urandom);
        return v;
    endfunction

    // Called at a negedge with the DUT idle; returns at the negedge after the output handshake.
    task automatic run_pass(input logic [N_IN*DW-1:0] x, input bit trace, input int stall,
                            output logic [127:0] got);
        int lat;
        logic [127:0] held;
        logic [127:0] exp;
        sb_q.push_back(model(x));
        bus.out_ready = (stall == 0);
        chk("in_ready_idle", 128'(bus.in_ready), 128'(1));
        bus.in_valid = 1'b1;
        bus.in_vec   = x;
        @(negedge clk);
        bus.in_valid = 1'b0;
        lat = -1;
        for (int i = 0; i < 400; i++) begin
            if (bus.out_valid) begin
                lat = i;
                break;
            end
            if (trace && i < LAT) begin
                if ((i % (N_IN+2)) <= N_IN) begin
                    chk("trace_w_en", 128'(bus.w_en), 128'(1));
                    chk("trace_w_addr", 128'(bus.w_addr), 128'((i/(N_IN+2))*(N_IN+1) + (i % (N_IN+2))));
                end else begin
                    chk("trace_w_en_write", 128'(bus.w_en), 128'(0));
                    chk("trace_w_addr_hold", 128'(bus.w_addr), 128'((i/(N_IN+2))*(N_IN+1) + N_IN));
                end
                chk("trace_busy", 128'(bus.busy), 128'(1));
            end
            @(negedge clk);
        end
        chk("latency", 128'(lat), 128'(LAT));
        if (lat >= 0) begin
            chk("done_in_ready", 128'(bus.in_ready), 128'(0));
            chk("done_busy", 128'(bus.busy), 128'(0));
            held = bus.out_vec;
            for (int s = 0; s < stall; s++) begin
                if (s == 2) begin
                    bus.in_valid = 1'b1;
                    bus.in_vec   = ~x;
                end
                @(negedge clk);
                chk("stall_out_valid", 128'(bus.out_valid), 128'(1));
                chk("stall_in_ready", 128'(bus.in_ready), 128'(0));
                chk("stall_out_vec", bus.out_vec, held);
            end
            bus.in_valid  = 1'b0;
            bus.out_ready = 1'b1;
        end
        exp = sb_q.pop_front();
        got = bus.out_vec;
        chk("out_vec", got, exp);
        @(negedge clk);
        chk("post_out_valid", 128'(bus.out_valid), 128'(0));
        chk("post_in_ready", 128'(bus.in_ready), 128'(1));
        if (stall > 0) begin
            repeat (3) @(negedge clk);
            chk("ignored_vec_busy", 128'(bus.busy), 128'(0));
            chk("ignored_vec_in_ready", 128'(bus.in_ready), 128'(1));
        end
    endtask

    initial begin
        logic [N_IN*DW-1:0] x;
        logic [127:0] got;

        reset         = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_vec    = '0;
        bus.out_ready = 1'b1;
        clear_rom();
        repeat (3) @(negedge clk);
        chk("rst_in_ready", 128'(bus.in_ready), 128'(1));
        chk("rst_out_valid", 128'(bus.out_valid), 128'(0));
        chk("rst_w_en", 128'(bus.w_en), 128'(0));
        chk("rst_w_addr", 128'(bus.w_addr), 128'(0));
        chk("rst_busy", 128'(bus.busy), 128'(0));
        chk("rst_out_vec", bus.out_vec, 128'(0));
        reset = 1'b0;
        @(negedge clk);

        // Zero weights, unit biases: every slot is 1, with a full address trace.
        for (int n = 0; n < N_OUT; n++) rom[n*(N_IN+1) + N_IN] = 16'd1;
        run_pass(rand_vec(), 1'b1, 0, got);
        chk("t1_all_ones", got, {N_OUT{16'd1}});

        // 3 * -5 + 1 = -14 clips to 0; other neurons see only their bias.
        clear_rom();
        rom[0]  = 16'hFFFB;
        rom[15] = 16'd1;
        for (int n = 1; n < N_OUT; n++) rom[n*(N_IN+1) + N_IN] = 16'(n * 100);
        x = '0;
        x[15:0] = 16'd3;
        run_pass(x, 1'b0, 0, got);
        chk("t2_relu_clip", 128'(got[15:0]), 128'(0));
        chk("t2_slot3_bias", 128'(got[63:48]), 128'(16'd300));

        // 300 * 300 = 90000 wraps to 24464.
        clear_rom();
        rom[0] = 16'd300;
        x = '0;
        x[15:0] = 16'd300;
        run_pass(x, 1'b0, 0, got);
        chk("t3_wrap", 128'(got[15:0]), 128'(16'd24464));

        // Random weights and activations.
        for (int r = 0; r < 3; r++) begin
            rand_rom();
            run_pass(rand_vec(), 1'b0, 0, got);
        end

        // Downstream stall for 20 cycles with a competing input vector.
        rand_rom();
        run_pass(rand_vec(), 1'b0, 20, got);

        // Reset at cycle 50 of a pass aborts it; the next pass still completes.
        rand_rom();
        bus.in_valid = 1'b1;
        bus.in_vec   = rand_vec();
        @(negedge clk);
        bus.in_valid = 1'b0;
        repeat (49) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("abort_in_ready", 128'(bus.in_ready), 128'(1));
        chk("abort_out_valid", 128'(bus.out_valid), 128'(0));
        chk("abort_out_vec", bus.out_vec, 128'(0));
        chk("abort_busy", 128'(bus.busy), 128'(0));
        chk("abort_w_en", 128'(bus.w_en), 128'(0));
        run_pass(rand_vec(), 1'b1, 0, got);

        chk("scoreboard_empty", 128'(sb_q.size()), 128'(0));
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire
